// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow controller.
// Holds state encoding, level codes and the level decode.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CD   = 3'd1,
    S_PLAY = 3'd2,
    S_DONE = 3'd3
  } state_t;

  localparam logic [2:0] LVL_EASY = 3'b001;
  localparam logic [2:0] LVL_MID  = 3'b010;
  localparam logic [2:0] LVL_HARD = 3'b100;

  localparam logic [2:0] SPD_EASY = 3'd1;
  localparam logic [2:0] SPD_MID  = 3'd2;
  localparam logic [2:0] SPD_HARD = 3'd4;

  localparam logic [4:0] CNT_EASY = 5'd8;
  localparam logic [4:0] CNT_MID  = 5'd12;
  localparam logic [4:0] CNT_HARD = 5'd16;

  typedef struct packed {
    logic       ok;
    logic [2:0] speed;
    logic [1:0] shamt;
    logic [4:0] total;
  } lvl_dec_t;

  function automatic lvl_dec_t decode_level(
    input logic [2:0] lvl
  );
    lvl_dec_t d;
    d = '0;
    case (lvl)
      LVL_EASY: d = '{1'b1, SPD_EASY, 2'd0, CNT_EASY};
      LVL_MID:  d = '{1'b1, SPD_MID,  2'd1, CNT_MID};
      LVL_HARD: d = '{1'b1, SPD_HARD, 2'd2, CNT_HARD};
      default:  d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/game_sequencer_spawn_timer.sv
// Interval down-counter issuing registered spawn pulses.
// due tells the owner a pulse is being issued on this edge.
module spawn_timer
  import game_pkg::*;
#(
  parameter int BASE_INTERVAL = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] shamt,
  input  logic       stop,
  output logic       due,
  output logic       spawn
);

  localparam int CW = (BASE_INTERVAL > 2) ? $clog2(BASE_INTERVAL) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] reload;
  logic          run_q;
  logic          spawn_q;

  assign reload = CW'((BASE_INTERVAL >> shamt) - 1);
  assign due    = run_q & (cnt_q == '0) & ~stop;
  assign spawn  = spawn_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      run_q   <= 1'b0;
      spawn_q <= 1'b0;
    end else begin
      spawn_q <= start | due;
      if (start | due) begin
        run_q <= 1'b1;
        cnt_q <= reload;
      end else if (stop) begin
        run_q <= 1'b0;
      end else if (run_q) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: level decode, countdown, spawning,
// hit/miss tally and round end.
module game_sequencer
  import game_pkg::*;
#(
  parameter int BASE_INTERVAL = 400,
  parameter int COUNTDOWN     = 100,
  parameter int LIVES         = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] level,
  input  logic       level_valid,
  input  logic       hit,
  input  logic       miss,
  output logic [2:0] state,
  output logic       game_en,
  output logic [2:0] speed,
  output logic       spawn,
  output logic [4:0] spawned,
  output logic [4:0] hits,
  output logic [4:0] misses,
  output logic [1:0] lives_left,
  output logic       game_over,
  output logic       cleared
);

  localparam int CDW = (COUNTDOWN > 2) ? $clog2(COUNTDOWN) : 1;
  localparam logic [CDW-1:0] CD_LOAD = CDW'(COUNTDOWN - 1);

  state_t         state_q;
  logic [CDW-1:0] cd_q;
  logic [2:0]     speed_q;
  logic [1:0]     shamt_q;
  logic [4:0]     total_q;
  logic [4:0]     spawned_q, hits_q, misses_q;
  logic [1:0]     lives_q;
  logic           game_en_q, over_q, clr_q;

  lvl_dec_t   dec;
  logic       in_play, start, stop, due, fire;
  logic       hit_c, miss_c, lose, win;
  logic [4:0] outst, hits_d, misses_d, res_d;
  logic [1:0] lives_d;

  assign dec     = decode_level(level);
  assign in_play = (state_q == S_PLAY);
  assign start   = (state_q == S_CD) & (cd_q == '0);
  assign fire    = start | due;

  // A simultaneous hit+miss on the last outstanding object keeps the hit.
  always_comb begin
    outst    = spawned_q - hits_q - misses_q;
    hit_c    = hit & in_play & (outst != 5'd0);
    miss_c   = miss & in_play & (outst != 5'd0)
             & ~(hit & (outst == 5'd1));
    hits_d   = hits_q + {4'd0, hit_c};
    misses_d = misses_q + {4'd0, miss_c};
    lives_d  = lives_q - {1'b0, miss_c};
    res_d    = hits_d + misses_d;
    lose     = miss_c & (lives_d == 2'd0);
    win      = in_play & ~lose & (res_d == total_q);
    stop     = ~in_play | (spawned_q >= total_q) | lose | win;
  end

  spawn_timer #(
    .BASE_INTERVAL(BASE_INTERVAL)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .shamt(shamt_q),
    .stop (stop),
    .due  (due),
    .spawn(spawn)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cd_q      <= '0;
      speed_q   <= '0;
      shamt_q   <= '0;
      total_q   <= '0;
      spawned_q <= '0;
      hits_q    <= '0;
      misses_q  <= '0;
      lives_q   <= '0;
      game_en_q <= 1'b0;
      over_q    <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (level_valid && dec.ok) begin
            state_q   <= S_CD;
            cd_q      <= CD_LOAD;
            speed_q   <= dec.speed;
            shamt_q   <= dec.shamt;
            total_q   <= dec.total;
            lives_q   <= 2'(LIVES);
            spawned_q <= '0;
            hits_q    <= '0;
            misses_q  <= '0;
            over_q    <= 1'b0;
            clr_q     <= 1'b0;
            game_en_q <= 1'b1;
          end
        end
        S_CD: begin
          if (start) begin
            state_q   <= S_PLAY;
            spawned_q <= spawned_q + 5'd1;
          end else begin
            cd_q <= cd_q - 1'b1;
          end
        end
        S_PLAY: begin
          hits_q   <= hits_d;
          misses_q <= misses_d;
          lives_q  <= lives_d;
          if (fire) spawned_q <= spawned_q + 5'd1;
          if (lose || win) begin
            state_q   <= S_DONE;
            over_q    <= lose;
            clr_q     <= win;
            game_en_q <= 1'b0;
            speed_q   <= '0;
          end
        end
        S_DONE: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign state      = state_q;
  assign game_en    = game_en_q;
  assign speed      = speed_q;
  assign spawned    = spawned_q;
  assign hits       = hits_q;
  assign misses     = misses_q;
  assign lives_left = lives_q;
  assign game_over  = over_q;
  assign cleared    = clr_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer (interval 8, countdown 4).
// Spawn pulses are checked by a monitor against queued expectations.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] level = 3'b000;
  logic       level_valid = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic [2:0] state;
  logic       game_en;
  logic [2:0] speed;
  logic       spawn;
  logic [4:0] spawned, hits, misses;
  logic [1:0] lives_left;
  logic       game_over, cleared;

  game_sequencer #(
    .BASE_INTERVAL(8),
    .COUNTDOWN    (4),
    .LIVES        (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .level      (level),
    .level_valid(level_valid),
    .hit        (hit),
    .miss       (miss),
    .state      (state),
    .game_en    (game_en),
    .speed      (speed),
    .spawn      (spawn),
    .spawned    (spawned),
    .hits       (hits),
    .misses     (misses),
    .lives_left (lives_left),
    .game_over  (game_over),
    .cleared    (cleared)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && spawn) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spawn_unexpected: got spawn at cyc %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("spawn_cyc", cyc, e.cyc);
        chk("spawn_cnt", int'(spawned), e.cnt);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic int all_out();
    return int'({state, game_en, speed, spawn, spawned, hits,
                 misses, lives_left, game_over, cleared});
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse(input logic h, input logic m);
    hit  = h;
    miss = m;
    @(negedge clk);
    hit  = 1'b0;
    miss = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    level_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_level(input logic [2:0] lv, output int acc);
    level = lv;
    level_valid = 1'b1;
    @(negedge clk);
    acc = cyc;
    chk("acc_state", int'(state), 1);
    chk("acc_game_en", int'(game_en), 1);
  endtask

  task automatic push_spawns(input int first, input int ivl, input int n);
    for (int k = 0; k < n; k++) sb.push_back('{first + k * ivl, k + 1});
  endtask

  // Easy round; mask bit k set means object k is missed, else hit.
  task automatic run_easy(input logic [7:0] mask);
    int acc;
    int nm;
    nm = $countones(mask);
    do_reset();
    start_level(3'b001, acc);
    chk("easy_speed", int'(speed), 1);
    chk("easy_lives", int'(lives_left), 3);
    push_spawns(acc + 4, 8, 8);
    for (int k = 0; k < 8; k++) begin
      wait_cyc(acc + 4 + 8 * k);
      pulse(!mask[k], mask[k]);
    end
    chk("end_state", int'(state), 3);
    chk("end_hits", int'(hits), 8 - nm);
    chk("end_misses", int'(misses), nm);
    chk("end_over", int'(game_over), (nm >= 3) ? 1 : 0);
    chk("end_cleared", int'(cleared), (nm >= 3) ? 0 : 1);
    chk("end_game_en", int'(game_en), 0);
    chk("end_speed", int'(speed), 0);
    repeat (12) @(negedge clk);
    chk("done_hold", int'(state), 3);
    chk("done_spawned", int'(spawned), 8);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int acc;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_out(), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_outs", all_out(), 0);

    run_easy(8'h00);

    do_reset();
    level = 3'b011;
    level_valid = 1'b1;
    repeat (6) @(negedge clk);
    chk("bad_lvl_state", int'(state), 0);
    chk("bad_lvl_en", int'(game_en), 0);
    start_level(3'b100, acc);
    chk("hard_speed", int'(speed), 4);
    push_spawns(acc + 4, 2, 16);
    wait_cyc(acc + 40);
    chk("hard_spawned", int'(spawned), 16);
    chk("hard_state", int'(state), 2);
    chk("sb_empty", sb.size(), 0);

    do_reset();
    start_level(3'b010, acc);
    chk("mid_speed", int'(speed), 2);
    push_spawns(acc + 4, 4, 3);
    wait_cyc(acc + 4);
    pulse(1'b0, 1'b1);
    chk("mid_lives1", int'(lives_left), 2);
    wait_cyc(acc + 8);
    pulse(1'b0, 1'b1);
    wait_cyc(acc + 12);
    pulse(1'b0, 1'b1);
    chk("mid_over", int'(game_over), 1);
    chk("mid_state", int'(state), 3);
    chk("mid_lives0", int'(lives_left), 0);
    chk("mid_spawned", int'(spawned), 3);
    wait_cyc(acc + 30);
    chk("mid_frozen", int'(spawned), 3);
    chk("sb_empty", sb.size(), 0);

    do_reset();
    start_level(3'b001, acc);
    push_spawns(acc + 4, 8, 4);
    pulse(1'b1, 1'b0);
    chk("cd_hit_ign", int'(hits), 0);
    wait_cyc(acc + 4);
    pulse(1'b1, 1'b0);
    chk("hit1", int'(hits), 1);
    pulse(1'b1, 1'b0);
    chk("hit_out0", int'(hits), 1);
    wait_cyc(acc + 12);
    pulse(1'b1, 1'b1);
    chk("both_out1_h", int'(hits), 2);
    chk("both_out1_m", int'(misses), 0);
    wait_cyc(acc + 28);
    pulse(1'b1, 1'b1);
    chk("both_out2_h", int'(hits), 3);
    chk("both_out2_m", int'(misses), 1);
    chk("both_out2_l", int'(lives_left), 2);
    wait_cyc(acc + 32);
    rst = 1'b0;
    #1;
    chk("midrst_outs", all_out(), 0);
    chk("sb_empty", sb.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    acc = cyc;
    chk("restart_state", int'(state), 1);
    chk("restart_spawned", int'(spawned), 0);
    push_spawns(acc + 4, 8, 1);
    wait_cyc(acc + 6);
    chk("sb_empty", sb.size(), 0);

    run_easy(8'b1000_0011);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
